// File: rtl/led_step_ctrl_if.sv
// Button inputs and run/mode/step/speed outputs of the LED step control stage.
// master drives the raw buttons; slave is the control stage.
interface led_step_ctrl_if;
  logic       BTN_SS;
  logic       BTN_MODE;
  logic       BTN_SPD;
  logic       SS;
  logic       MODE;
  logic       STEP;
  logic [1:0] SPD;

  modport master (
    output BTN_SS, BTN_MODE, BTN_SPD,
    input  SS, MODE, STEP, SPD
  );

  modport slave (
    input  BTN_SS, BTN_MODE, BTN_SPD,
    output SS, MODE, STEP, SPD
  );
endinterface

// File: rtl/led_step_ctrl.sv
// Debounced start/stop and mode toggles plus a step-enable prescaler for the LED pattern block.
// Defining LED_STEP_SPEED_EN adds a debounced speed button cycling the step period DIV>>SPD.
module led_step_ctrl #(
  parameter int unsigned DIV       = 50_000_000,
  parameter int unsigned DB_CYCLES = 500_000
) (
  input logic            Clk,
  input logic            RST,
  led_step_ctrl_if.slave bus
);

`ifdef LED_STEP_SPEED_EN
  localparam int unsigned NumBtn = 3;
`else
  localparam int unsigned NumBtn = 2;
`endif
  localparam int unsigned BtnSs   = 0;
  localparam int unsigned BtnMode = 1;
  localparam int unsigned DbW     = $clog2(DB_CYCLES + 1);
  localparam int unsigned CntW    = $clog2(DIV);
  localparam logic [31:0] DbLast  = 32'(DB_CYCLES - 1);
  localparam logic [31:0] DivW    = 32'(DIV);

  logic [NumBtn-1:0] btn_raw;
  logic [NumBtn-1:0] sync1_q, sync2_q, level_q, press_q;
  logic [DbW-1:0]    db_cnt_q [NumBtn];

  assign btn_raw[BtnSs]   = bus.BTN_SS;
  assign btn_raw[BtnMode] = bus.BTN_MODE;
`ifdef LED_STEP_SPEED_EN
  assign btn_raw[2] = bus.BTN_SPD;
`else
  logic unused_btn_spd;
  assign unused_btn_spd = bus.BTN_SPD;
`endif

  // Press pulse is registered with the level update, so a toggle lands DB_CYCLES+2 edges
  // after the first high sample.
  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      press_q <= '0;
      for (int i = 0; i < NumBtn; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < NumBtn; i++) begin
        press_q[i] <= 1'b0;
        if (sync2_q[i] == level_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DbLast[DbW-1:0]) begin
          level_q[i]  <= sync2_q[i];
          press_q[i]  <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  logic            ss_q, ss_d;
  logic            mode_q, mode_d;
  logic            step_q, step_d;
  logic            spd_chg;
  logic [1:0]      spd_q, spd_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     p_last;

  always_comb begin
    ss_d   = ss_q ^ press_q[BtnSs];
    mode_d = mode_q ^ press_q[BtnMode];
`ifdef LED_STEP_SPEED_EN
    spd_d   = spd_q + {1'b0, press_q[2]};
    spd_chg = press_q[2];
`else
    spd_d   = 2'b00;
    spd_chg = 1'b0;
`endif
    p_last = (DivW >> spd_q) - 32'd1;
    cnt_d  = '0;
    step_d = 1'b0;
    // Counting needs a run both before and after this edge; start, stop, mode and speed
    // changes all restart the period from zero without a step.
    if (ss_q && ss_d && !press_q[BtnMode] && !spd_chg) begin
      if (cnt_q == p_last[CntW-1:0]) begin
        step_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      ss_q   <= 1'b0;
      mode_q <= 1'b0;
      step_q <= 1'b0;
      spd_q  <= 2'b00;
      cnt_q  <= '0;
    end else begin
      ss_q   <= ss_d;
      mode_q <= mode_d;
      step_q <= step_d;
      spd_q  <= spd_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.SS   = ss_q;
  assign bus.MODE = mode_q;
  assign bus.STEP = step_q;
  assign bus.SPD  = spd_q;

endmodule

// File: doc/led_step_ctrl.md
# led_step_ctrl

Front-end control stage for the 8-LED centre/edge shift pattern block. Debounces the start/stop and mode push buttons, converts each press into a level toggle, and divides the system clock into a one-cycle step enable. Its outputs drive the pattern block's run, mode and step-enable inputs, so the pattern advances at a visible rate.

## Interface
- DIV, default 50_000_000: Clk cycles per step at speed 0. Must be at least 8 and a multiple of 8.
- DB_CYCLES, default 500_000: consecutive stable samples required to accept a button level. Must be at least 1.
- Clk  input  1  system clock, all logic on the rising edge
- RST  input  1  reset: RST, asynchronous, active-high; clock Clk
- BTN_SS  input  1  raw start/stop button, active-high, asynchronous to Clk
- BTN_MODE  input  1  raw mode button, active-high, asynchronous to Clk
- BTN_SPD  input  1  raw speed button, active-high; ignored unless the macro is defined
- SS  output  1  run level; 1 = pattern advances
- MODE  output  1  direction level; 1 = edges inward, 0 = centre outward
- STEP  output  1  one-Clk pulse, one per pattern step
- SPD  output  2  current speed index

## Operation
- Reset values: SS=0, MODE=0, STEP=0, SPD=2'b00. Synchronisers, debounced levels, debounce counters and the prescaler all reset to 0.
- Per button path:
  - 2-FF synchroniser.
  - Debounce counter: increments while the synchronised value differs from the debounced level. It clears on any cycle where they match. When it reaches DB_CYCLES, the debounced level takes the synchronised value and the counter clears.
  - Press pulse: one cycle, on a 0→1 transition of the debounced level. Releases generate nothing.
- SS toggles on each SS press. MODE toggles on each MODE press, whether SS is 0 or 1.
- Prescaler, period P = DIV >> SPD:
  - SS=0: count held at 0, STEP=0.
  - SS=1: count runs 0..P-1. STEP=1 in the cycle count==P-1, then count wraps to 0.
  - The first STEP after SS rises comes P cycles after the rise.
- Prescaler clears to 0 on:
  - a MODE toggle, so the new direction gets a full period, and
  - an SPD change.
  Neither event produces a STEP in that cycle.
- Simultaneous events:
  - SS and MODE presses in the same cycle both apply.
  - An SS press that stops the run in the same cycle count==P-1 suppresses that STEP.
- A button held through RST deassertion produces exactly one press, DB_CYCLES+3 edges after deassertion.

## Timing
- BTN_SS held high and stable from Clk edge E (first edge that samples it high): SS toggles at edge E+DB_CYCLES+2. It is visible after that edge. MODE and SPD have the same latency.
- A glitch shorter than DB_CYCLES samples causes no toggle.
- STEP is registered and always exactly 1 cycle wide. Its period is exactly P while SS=1 and no clear event occurs.
- RST asynchronously forces all state to reset values mid-operation. The first action after release is the next accepted press.

## Configuration
- LED_STEP_SPEED_EN defined:
  - Third debounced path on BTN_SPD.
  - Each press advances SPD 0→1→2→3→0, so P = DIV, DIV/2, DIV/4, DIV/8.
  - The prescaler clears on each change.
- Not defined:
  - BTN_SPD is unused and no third path is built.
  - SPD is constant 2'b00, and P = DIV.

## Test plan
Bench parameters: DIV=8, DB_CYCLES=4.
- Reset: RST pulsed mid-run with SS=1 → SS=0, MODE=0, STEP=0, SPD=0 immediately, with no STEP until the next SS press.
- Start: BTN_SS high 10 cycles, then low → SS=1 at edge E+6. STEP pulses every 8 cycles, first at 8 cycles after SS rises. A second press sets SS=0 and STEP stays 0.
- Glitch: BTN_SS high 3 cycles → SS unchanged. Bounce 1-0-1-0-1 then stable high → exactly one toggle.
- Mode: press BTN_MODE while SS=1 and count=5 → MODE toggles, the prescaler restarts, and the next STEP comes 8 cycles later. Press with SS=0 → MODE still toggles and no STEP occurs.
- Simultaneous: BTN_SS and BTN_MODE rise on the same edge → SS and MODE toggle on the same edge.
- Speed (LED_STEP_SPEED_EN): 4 presses of BTN_SPD → STEP periods 8, 4, 2, 1, then back to 8 with SPD=0. Without the macro, BTN_SPD presses leave SPD=0 and the period at 8.
